gaussian_loop_ctrl: RTL and testbench

- Sequencing controller directly upstream of the gaussian datapath. Owns the loop state: registers the datapath's next-value outputs back into its induction-variable inputs and drives the enablePhi selects.
- Steps BB_1 (outer i) → BB_4 (middle j) → BB_5 (pipelined inner k) → BB_6 (j latch), then signals end of circuit.
- Tracks inner-loop pipeline occupancy and generates the store strobe.

---
 rtl/gaussian_loop_ctrl.sv | 164 ++++++++++++++++
 tb/tb_gaussian_loop_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_loop_ctrl.sv
// gaussian_loop_ctrl: sequencing controller for the gaussian datapath.
// Walks BB_1 (outer i) -> BB_4 (middle j) -> BB_5 (pipelined inner k) ->
// BB_6 (j latch), feeds the datapath's next-value outputs back into its
// induction-variable inputs and produces the store strobe.
// Optional build macro GAUSS_CTRL_PERF_EN adds perf_cycles / perf_stores.
module gaussian_loop_ctrl #(
    parameter int PIPE_DEPTH = 2,   // BB_5 issue to store, 1..4
    parameter int K_W        = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stall,
    input  logic           n217_ctrlOut_BB_1,
    input  logic           n282_ctrlOut_BB_6,
    input  logic           n382_ctrlOut_BB_5,
    input  logic [3:0]     ngaussian_loopexitloopexit_8_reg_po_BB_1,
    input  logic [K_W-1:0] ngaussian_20_21_po_BB_4,
    input  logic [K_W-1:0] n386_po_BB_5,
    output logic           gaussian_loopexitloopexit_1_reg_enablePhi_BB_1,
    output logic           gaussian_lrph_indvar4_reg_enablePhi_BB_4,
    output logic           LOOP22_1_inductionVar_stage0_enablePhi_BB_5,
    output logic [3:0]     ngaussian_loopexitloopexit_1_reg_pi_BB_1,
    output logic [K_W-1:0] ngaussian_lrph_indvar4_reg_pi_BB_4,
    output logic [K_W-1:0] nLOOP22_1_inductionVar_stage0_pi_BB_5,
    output logic           pipe_en,
    output logic           store_en,
    output logic           busy,
    output logic           endCircuit_endCircuitPI
`ifdef GAUSS_CTRL_PERF_EN
    ,
    output logic [31:0]    perf_cycles,
    output logic [31:0]    perf_stores
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_BB1, S_BB4, S_BB5, S_BB5_DRAIN, S_BB6, S_DONE
    } state_t;

    state_t                state, state_n;
    logic [PIPE_DEPTH-1:0] valid_sr, valid_sr_n;
    logic [2:0]            drain_cnt, drain_n;
    logic                  push;
    logic                  en1_n, en4_n, en5_n;
    logic [3:0]            pi1_n;
    logic [K_W-1:0]        pi4_n, pi5_n;

    // State register; a stall freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        state <= S_IDLE;
        else if (!stall) state <= state_n;
    end

    // Next state, loop-register updates and pipeline push.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        drain_n = drain_cnt;
        en1_n   = gaussian_loopexitloopexit_1_reg_enablePhi_BB_1;
        en4_n   = gaussian_lrph_indvar4_reg_enablePhi_BB_4;
        en5_n   = LOOP22_1_inductionVar_stage0_enablePhi_BB_5;
        pi1_n   = ngaussian_loopexitloopexit_1_reg_pi_BB_1;
        pi4_n   = ngaussian_lrph_indvar4_reg_pi_BB_4;
        pi5_n   = nLOOP22_1_inductionVar_stage0_pi_BB_5;
        case (state)
            S_IDLE: if (start) begin
                state_n = S_BB1;
                en1_n   = 1'b1;
                en4_n   = 1'b1;
                en5_n   = 1'b1;
            end
            S_BB1: begin
                if (n217_ctrlOut_BB_1) state_n = S_DONE;
                else begin
                    state_n = S_BB4;
                    en4_n   = 1'b1;
                end
            end
            S_BB4: begin
                state_n = S_BB5;
                en5_n   = 1'b1;
            end
            S_BB5: begin
                push  = 1'b1;
                pi5_n = n386_po_BB_5;
                en5_n = 1'b0;
                if (n382_ctrlOut_BB_5) begin
                    state_n = S_BB5_DRAIN;
                    drain_n = 3'd0;
                end
            end
            S_BB5_DRAIN: begin
                // Wait until the last issue has reached its store slot.
                drain_n = drain_cnt + 3'd1;
                if (drain_cnt == 3'(PIPE_DEPTH - 1)) state_n = S_BB6;
            end
            S_BB6: begin
                if (n282_ctrlOut_BB_6) begin
                    pi1_n   = ngaussian_loopexitloopexit_8_reg_po_BB_1;
                    en1_n   = 1'b0;
                    en4_n   = 1'b1;
                    state_n = S_BB1;
                end else begin
                    pi4_n   = ngaussian_20_21_po_BB_4;
                    en4_n   = 1'b0;
                    state_n = S_BB4;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        valid_sr_n = (valid_sr << 1) | PIPE_DEPTH'(push);
    end

    // Loop registers, phi selects and the issue-valid shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_sr                                        <= '0;
            drain_cnt                                       <= '0;
            gaussian_loopexitloopexit_1_reg_enablePhi_BB_1  <= 1'b1;
            gaussian_lrph_indvar4_reg_enablePhi_BB_4        <= 1'b1;
            LOOP22_1_inductionVar_stage0_enablePhi_BB_5     <= 1'b1;
            ngaussian_loopexitloopexit_1_reg_pi_BB_1        <= '0;
            ngaussian_lrph_indvar4_reg_pi_BB_4              <= '0;
            nLOOP22_1_inductionVar_stage0_pi_BB_5           <= '0;
        end else if (!stall) begin
            valid_sr                                        <= valid_sr_n;
            drain_cnt                                       <= drain_n;
            gaussian_loopexitloopexit_1_reg_enablePhi_BB_1  <= en1_n;
            gaussian_lrph_indvar4_reg_enablePhi_BB_4        <= en4_n;
            LOOP22_1_inductionVar_stage0_enablePhi_BB_5     <= en5_n;
            ngaussian_loopexitloopexit_1_reg_pi_BB_1        <= pi1_n;
            ngaussian_lrph_indvar4_reg_pi_BB_4              <= pi4_n;
            nLOOP22_1_inductionVar_stage0_pi_BB_5           <= pi5_n;
        end
    end

    // Outputs; the completion pulse is gated so a stalled DONE still yields one pulse.
    always_comb begin
        pipe_en                 = ~stall;
        store_en                = valid_sr[PIPE_DEPTH-1] & ~stall;
        busy                    = (state != S_IDLE);
        endCircuit_endCircuitPI = (state == S_DONE) & ~stall;
    end

`ifdef GAUSS_CTRL_PERF_EN
    // Run counters; the completion cycle itself is not counted so the value
    // seen alongside endCircuit is already final.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_stores <= '0;
        end else if (state == S_IDLE && start && !stall) begin
            perf_cycles <= '0;
            perf_stores <= '0;
        end else begin
            if (busy && state != S_DONE) perf_cycles <= perf_cycles + 32'd1;
            if (store_en)                perf_stores <= perf_stores + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gaussian_loop_ctrl.sv
// Bench for gaussian_loop_ctrl: behavioural datapath stand-in, a loop-nest
// reference schedule, a table of run configurations and reset/stall sequences.
module tb_gaussian_loop_ctrl;
    localparam int PD    = 2;
    localparam int K_W   = 32;
    localparam int LIMIT = 8000;

    logic clk = 1'b0;
    logic rst, start, stall;
    logic n217, n282, n382;
    logic [3:0] po1;
    logic [K_W-1:0] po4, po5;
    logic en1, en4, en5;
    logic [3:0] pi1;
    logic [K_W-1:0] pi4, pi5;
    logic pipe_en, store_en, busy, end_pulse;
`ifdef GAUSS_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stores;
`endif

    int n_err = 0;
    int n_chk = 0;
    int exp_q[$];
    int done_u;

    always #5 clk = ~clk;

    gaussian_loop_ctrl #(.PIPE_DEPTH(PD), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .n217_ctrlOut_BB_1(n217), .n282_ctrlOut_BB_6(n282), .n382_ctrlOut_BB_5(n382),
        .ngaussian_loopexitloopexit_8_reg_po_BB_1(po1),
        .ngaussian_20_21_po_BB_4(po4),
        .n386_po_BB_5(po5),
        .gaussian_loopexitloopexit_1_reg_enablePhi_BB_1(en1),
        .gaussian_lrph_indvar4_reg_enablePhi_BB_4(en4),
        .LOOP22_1_inductionVar_stage0_enablePhi_BB_5(en5),
        .ngaussian_loopexitloopexit_1_reg_pi_BB_1(pi1),
        .ngaussian_lrph_indvar4_reg_pi_BB_4(pi4),
        .nLOOP22_1_inductionVar_stage0_pi_BB_5(pi5),
        .pipe_en(pipe_en), .store_en(store_en), .busy(busy),
        .endCircuit_endCircuitPI(end_pulse)
`ifdef GAUSS_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stores(perf_stores)
`endif
    );

    // Datapath stand-in: i in 0..14, j in i+1..14, k in 0..14.
    logic [3:0]     i_cur;
    logic [K_W-1:0] j_cur, k_cur;
    always_comb begin
        i_cur = en1 ? 4'd0 : pi1;
        j_cur = en4 ? (K_W'(i_cur) + K_W'(1)) : pi4;
        k_cur = en5 ? '0 : pi5;
        n217  = (i_cur == 4'd14);
        po1   = i_cur + 4'd1;
        n282  = (j_cur == K_W'(14));
        po4   = j_cur + K_W'(1);
        n382  = (k_cur == K_W'(14));
        po5   = k_cur + K_W'(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference schedule in unstalled cycles after the start edge: BB1 and BB4
    // take one cycle, each k issue one, then PD drain cycles and one BB6 cycle.
    task automatic build_model();
        int t;
        t = 0;
        exp_q.delete();
        for (int i = 0; i < 14; i++) begin
            t++;
            for (int j = i + 1; j <= 14; j++) begin
                t++;
                for (int k = 0; k <= 14; k++) begin
                    t++;
                    exp_q.push_back(t + PD);
                end
                t += PD;
                t++;
            end
        end
        t++;            // final BB1 sees i==14
        done_u = t + 1; // DONE
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_store"}, store_en, 0);
        chk({tag, "_end"}, end_pulse, 0);
        chk({tag, "_en_all"}, {en1, en4, en5}, 3'b111);
        chk({tag, "_pi1"}, pi1, 0);
        chk({tag, "_pi4"}, pi4, 0);
        chk({tag, "_pi5"}, pi5, 0);
    endtask

    typedef struct {
        int stall_pct;
        bit spam;
        int win_at;
        int win_len;
        bit inner;
        int exp_stores;
        int exp_end;  // -1: completion cycle depends on random stalls
    } vec_t;

    task automatic run_one(input vec_t v);
        int q[$];
        int u, n_st, sched_err, frz_err, end_c, pre_done;
        logic [K_W-1:0] frz_ref;
        q = exp_q;
        u = 0; n_st = 0; sched_err = 0; frz_err = 0; end_c = -1; pre_done = -1;
        frz_ref = '0;
        @(negedge clk);
        start = 1'b1;
        stall = 1'b0;
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            start = v.spam ? 1'($urandom_range(0, 1)) : 1'b0;
            if (v.win_len > 0 && c >= v.win_at && c < v.win_at + v.win_len)
                stall = 1'b1;
            else
                stall = (v.stall_pct > 0) && ($urandom_range(0, 99) < v.stall_pct);
            #1;
            if (!stall) u++;
            if (!stall && u == done_u - 1) pre_done = c;
            if (v.win_len > 0 && c == v.win_at) frz_ref = pi5;
            if (v.win_len > 0 && c >= v.win_at && c < v.win_at + v.win_len)
                if (pi5 != frz_ref || store_en || pipe_en) frz_err++;
            if (v.inner) begin
                if (c == 2) chk("bb4_en4", en4, 1);
                if (c == 3) chk("bb5_first_en5", en5, 1);
                if (c == 4) chk("bb5_k1", {en5, pi5}, {1'b0, K_W'(1)});
                if (c == 21) chk("bb6_j_latch", {en4, pi4}, {1'b0, K_W'(2)});
            end
            if (store_en) begin
                n_st++;
                if (stall || q.size() == 0 || q[0] != u) sched_err++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (end_pulse) begin
                if (stall || u != done_u) sched_err++;
                end_c = c;
                break;
            end
        end
        chk("completed", end_c > 0, 1);
        chk("stores", n_st, v.exp_stores);
        chk("store_sched", sched_err, 0);
        chk("pi_BB_1_final", pi1, 14);
        if (v.exp_end >= 0) chk("end_cycle", end_c, v.exp_end);
        if (v.win_len > 0) chk("stall_freeze", frz_err, 0);
`ifdef GAUSS_CTRL_PERF_EN
        chk("perf_stores", perf_stores, v.exp_stores);
        chk("perf_cycles", perf_cycles, pre_done);
`endif
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
        #1;
        chk("busy_drop", busy, 0);
        chk("end_one_cycle", end_pulse, 0);
        if (end_c < 0) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end
    endtask

    vec_t vecs[5];
    bit   found;

    initial begin
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        build_model();
        chk("model_stores", exp_q.size(), 1575);
        chk("model_done", done_u, 2011);
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("por");
        rst = 1'b1;

        // Mid-BB5 abort: reset lands between edges while stores are flowing.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (store_en) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("rst_reach_bb5", found, 1);
        #2 rst = 1'b0;
        #1 check_reset_state("abort");
        @(negedge clk);
        #1 check_reset_state("abort_hold");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("abort_no_store", store_en, 0);
        chk("abort_idle", busy, 0);

        vecs[0] = '{stall_pct: 0,  spam: 0, win_at: 0, win_len: 0, inner: 1, exp_stores: 1575, exp_end: 2011};
        vecs[1] = '{stall_pct: 0,  spam: 0, win_at: 8, win_len: 5, inner: 0, exp_stores: 1575, exp_end: 2016};
        vecs[2] = '{stall_pct: 20, spam: 0, win_at: 0, win_len: 0, inner: 0, exp_stores: 1575, exp_end: -1};
        vecs[3] = '{stall_pct: 0,  spam: 1, win_at: 0, win_len: 0, inner: 1, exp_stores: 1575, exp_end: 2011};
        vecs[4] = '{stall_pct: 35, spam: 1, win_at: 0, win_len: 0, inner: 0, exp_stores: 1575, exp_end: -1};
        foreach (vecs[r]) run_one(vecs[r]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
